// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes on rx_i, packs them into instruction words
// and writes them sequentially into instruction memory until the end marker arrives.
module uart_prog_loader #(
   parameter int unsigned       WORD_W        = 32,
   parameter int unsigned       ADDR_W        = 10,
   parameter bit                LITTLE_ENDIAN = 1'b1,
   parameter logic [WORD_W-1:0] END_WORD      = WORD_W'(32'h0000_0FFF),
   parameter int unsigned       DIV_W         = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              en_i,
   input  logic [DIV_W-1:0]  clks_per_bit_i,
   input  logic              rx_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              frame_err_o,
   output logic              overflow_o,
   output logic [ADDR_W:0]   word_cnt_o
);

   localparam int unsigned NB    = WORD_W / 8;
   localparam int unsigned BC_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(NB - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Receiver state; rx_state_q is the observable FSM state.
   rx_state_t        rx_state_q;
   logic             rx_meta_q;
   logic             rx_sync_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] tick_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             byte_valid_q;
   logic             frame_bad_q;

   // Assembler and memory-port state.
   logic              en_q;
   logic              busy_q;
   logic              done_q;
   logic              ferr_q;
   logic              ovf_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [CNT_W-1:0]  wcnt_q;
   logic [BC_W-1:0]   byte_cnt_q;
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] word_d;

   logic             en_rise;
   logic [DIV_W-1:0] half_last;
   logic [DIV_W-1:0] bit_last;

   assign en_rise   = en_i & ~en_q;
   assign half_last = (div_q >> 1) - DIV_W'(1);
   assign bit_last  = div_q - DIV_W'(1);

   // Receiver: 2-flop synchroniser, start-bit check at half a bit, then centre sampling.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         div_q        <= '0;
         tick_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_bad_q  <= 1'b0;
      end else begin
         rx_meta_q    <= rx_i;
         rx_sync_q    <= rx_meta_q;
         byte_valid_q <= 1'b0;
         frame_bad_q  <= 1'b0;
         if (!en_i) begin
            rx_state_q <= RX_IDLE;
            tick_q     <= '0;
         end else begin
            case (rx_state_q)
               RX_IDLE: begin
                  tick_q <= '0;
                  if (!rx_sync_q && !done_q) begin
                     rx_state_q <= RX_START;
                     div_q      <= clks_per_bit_i;
                  end
               end
               RX_START: begin
                  if (tick_q == half_last) begin
                     tick_q    <= '0;
                     bit_idx_q <= '0;
                     rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                  end else begin
                     tick_q <= tick_q + DIV_W'(1);
                  end
               end
               RX_DATA: begin
                  if (tick_q == bit_last) begin
                     tick_q  <= '0;
                     shift_q <= {rx_sync_q, shift_q[7:1]};
                     if (bit_idx_q == 3'd7) begin
                        rx_state_q <= RX_STOP;
                     end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                     end
                  end else begin
                     tick_q <= tick_q + DIV_W'(1);
                  end
               end
               RX_STOP: begin
                  if (tick_q == bit_last) begin
                     tick_q     <= '0;
                     rx_state_q <= RX_IDLE;
                     if (rx_sync_q) begin
                        byte_valid_q <= 1'b1;
                     end else begin
                        frame_bad_q <= 1'b1;
                     end
                  end else begin
                     tick_q <= tick_q + DIV_W'(1);
                  end
               end
               default: rx_state_q <= RX_IDLE;
            endcase
         end
      end
   end

   // Place the received byte into the word according to byte order.
   always_comb begin
      word_d = word_q;
      for (int i = 0; i < NB; i++) begin
         if (LITTLE_ENDIAN) begin
            if (byte_cnt_q == BC_W'(i)) word_d[8*i +: 8] = shift_q;
         end else begin
            if (byte_cnt_q == BC_W'(NB - 1 - i)) word_d[8*i +: 8] = shift_q;
         end
      end
   end

   // Memory port: mem_req_o is valid, mem_gnt_i is ready; a write completes in the
   // cycle where both are high, and addr/wdata stay frozen while the request waits.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wcnt_q     <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
      end else begin
         en_q   <= en_i;
         busy_q <= en_i & ~done_q;
         if (req_q && mem_gnt_i) begin
            req_q  <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
            if (wcnt_q != DEPTH) wcnt_q <= wcnt_q + CNT_W'(1);
         end
         if (en_rise) begin
            addr_q     <= '0;
            wcnt_q     <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
         end else if (!en_i) begin
            byte_cnt_q <= '0;
         end else if (frame_bad_q) begin
            ferr_q     <= 1'b1;
            byte_cnt_q <= '0;
         end else if (byte_valid_q && !done_q) begin
            word_q <= word_d;
            if (byte_cnt_q == BC_LAST) begin
               byte_cnt_q <= '0;
               if (word_d == END_WORD) begin
                  done_q <= 1'b1;
               end else if (wcnt_q == DEPTH || req_q) begin
                  ovf_q <= 1'b1;
               end else begin
                  req_q   <= 1'b1;
                  wdata_q <= word_d;
               end
            end else begin
               byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
         end
      end
   end

   assign mem_req_o   = req_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign frame_err_o = ferr_q;
   assign overflow_o  = ovf_q;
   assign word_cnt_o  = wcnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a little-endian 4-deep instance and a big-endian
// 1024-deep instance share one serial line, enable and grant.
module tb_uart_prog_loader;

   localparam int DIV = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] div = 16'(DIV);
   logic        rx  = 1'b1;
   logic        gnt = 1'b0;

   logic        le_req, le_busy, le_done, le_ferr, le_ovf;
   logic [1:0]  le_addr;
   logic [31:0] le_wdata;
   logic [2:0]  le_wcnt;
   logic        be_req, be_busy, be_done, be_ferr, be_ovf;
   logic [9:0]  be_addr;
   logic [31:0] be_wdata;
   logic [10:0] be_wcnt;

   int n_pass  = 0;
   int n_total = 0;
   int le_gnts = 0;
   int be_gnts = 0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic [31:0] tx;    // tx[7:0] goes on the line first
      logic [31:0] le_w;
      logic [31:0] be_w;
   } vec_t;

   vec_t vecs[3];

   uart_prog_loader #(.WORD_W(32), .ADDR_W(2), .LITTLE_ENDIAN(1'b1)) dut_le (
      .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .clks_per_bit_i(div), .rx_i(rx),
      .mem_req_o(le_req), .mem_gnt_i(gnt), .mem_addr_o(le_addr), .mem_wdata_o(le_wdata),
      .busy_o(le_busy), .done_o(le_done), .frame_err_o(le_ferr), .overflow_o(le_ovf),
      .word_cnt_o(le_wcnt)
   );

   uart_prog_loader #(.WORD_W(32), .ADDR_W(10), .LITTLE_ENDIAN(1'b0)) dut_be (
      .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .clks_per_bit_i(div), .rx_i(rx),
      .mem_req_o(be_req), .mem_gnt_i(gnt), .mem_addr_o(be_addr), .mem_wdata_o(be_wdata),
      .busy_o(be_busy), .done_o(be_done), .frame_err_o(be_ferr), .overflow_o(be_ovf),
      .word_cnt_o(be_wcnt)
   );

   // Clock and accepted-write counters
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && le_req && gnt) le_gnts <= le_gnts + 1;
      if (!rst && be_req && gnt) be_gnts <= be_gnts + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_bit;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] tx);
      for (int i = 0; i < 4; i++) send_byte(tx[8*i +: 8], 1'b1);
   endtask

   task automatic wait_req(input bit want_le, input bit want_be, input string name);
      int n;
      n = 0;
      while (n < 200 && !((!want_le || le_req) && (!want_be || be_req))) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({name, "_req_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic grant_one();
      @(negedge clk);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
   endtask

   task automatic en_toggle();
      @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int g_le;
      int g_be;
      vecs[0] = '{tx: 32'h1234_5678, le_w: 32'h1234_5678, be_w: 32'h7856_3412};
      vecs[1] = '{tx: 32'h7856_3412, le_w: 32'h7856_3412, be_w: 32'h1234_5678};
      vecs[2] = '{tx: 32'hDDCC_BBAA, le_w: 32'hDDCC_BBAA, be_w: 32'hAABB_CCDD};

      // Reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_le_req", le_req, 0);
      check("rst_le_flags", {le_busy, le_done, le_ferr, le_ovf}, 0);
      check("rst_le_addr_cnt", {le_addr, le_wcnt}, 0);
      check("rst_be_req", be_req, 0);
      check("rst_be_flags", {be_busy, be_done, be_ferr, be_ovf}, 0);
      check("rst_be_addr_cnt_data", {be_addr, be_wcnt, be_wdata}, 0);

      en = 1'b1;
      repeat (2) @(negedge clk);
      check("busy_le", le_busy, 1);
      check("busy_be", be_busy, 1);

      // Table: one word per record, grant 3 cycles after the request appears
      for (int v = 0; v < 3; v++) begin
         exp_q.push_back(vecs[v].le_w);
         exp_q.push_back(vecs[v].be_w);
         send_word(vecs[v].tx);
         wait_req(1'b1, 1'b1, "tbl");
         check("tbl_le_wdata", le_wdata, exp_q.pop_front());
         check("tbl_be_wdata", be_wdata, exp_q.pop_front());
         check("tbl_le_addr", le_addr, 64'(v));
         check("tbl_be_addr", be_addr, 64'(v));
         repeat (3) @(negedge clk);
         check("tbl_held", {le_req, be_req, le_wdata}, {2'b11, vecs[v].le_w});
         grant_one();
         check("tbl_req_fall", {le_req, be_req}, 0);
         check("tbl_le_cnt", {le_wcnt, le_addr}, {3'(v + 1), 2'(v + 1)});
         check("tbl_be_cnt", {be_wcnt, be_addr}, {11'(v + 1), 10'(v + 1)});
      end

      // Bad stop bit on the 2nd byte drops the partial word
      en_toggle();
      check("ferr_clear_addr", {le_addr, le_wcnt, be_addr, be_wcnt}, 0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      check("ferr_set", {le_ferr, be_ferr}, 2'b11);
      check("ferr_no_req", {le_req, be_req}, 0);
      send_word(32'hDDCC_BBAA);
      wait_req(1'b1, 1'b1, "ferr");
      check("ferr_le_wdata", le_wdata, 32'hDDCC_BBAA);
      check("ferr_be_wdata", be_wdata, 32'hAABB_CCDD);
      check("ferr_addr", {le_addr, be_addr}, 0);
      grant_one();

      // Two-clock glitch on rx is not a start bit
      en_toggle();
      @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      check("glitch_le", {le_req, le_done, le_ferr, le_ovf, le_wcnt}, 0);
      check("glitch_be", {be_req, be_done, be_ferr, be_ovf, be_wcnt}, 0);

      // Grant held high: the 4-deep instance fills and overflows on word 5
      en_toggle();
      g_le = le_gnts;
      g_be = be_gnts;
      @(negedge clk);
      gnt = 1'b1;
      for (int k = 1; k <= 5; k++) send_word(32'(k));
      repeat (4) @(negedge clk);
      gnt = 1'b0;
      check("full_le_writes", le_gnts - g_le, 4);
      check("full_le_state", {le_wcnt, le_addr, le_ovf, le_req}, {3'd4, 2'd0, 1'b1, 1'b0});
      check("full_be_writes", be_gnts - g_be, 5);
      check("full_be_state", {be_wcnt, be_addr, be_ovf}, {11'd5, 10'd5, 1'b0});

      // Second word while the first is still pending
      en_toggle();
      send_word(32'h0403_0201);
      wait_req(1'b1, 1'b1, "pend");
      send_word(32'h0807_0605);
      check("pend_ovf", {le_ovf, be_ovf}, 2'b11);
      check("pend_kept", {le_req, be_req, le_wdata, be_wdata}, {2'b11, 32'h0403_0201, 32'h0102_0304});
      check("pend_addr", {le_addr, be_addr}, 0);
      en_toggle();
      check("pend_clear_le", {le_ovf, le_ferr, le_done, le_addr, le_wcnt}, 0);
      check("pend_clear_be", {be_ovf, be_ferr, be_done, be_addr, be_wcnt}, 0);
      check("pend_still_req", {le_req, be_req}, 2'b11);
      grant_one();
      check("pend_done", {le_req, be_req, le_wcnt}, {2'b00, 3'd1});

      // End marker: little-endian sees it on word 2, big-endian on word 3
      en_toggle();
      send_word(32'h7856_3412);
      wait_req(1'b1, 1'b1, "end1");
      check("end_w1_le", le_wdata, 32'h7856_3412);
      check("end_w1_be", be_wdata, 32'h1234_5678);
      grant_one();
      g_le = le_gnts;
      send_word(32'h0000_0FFF);
      wait_req(1'b0, 1'b1, "end2");
      check("end_le_done", {le_done, le_req}, 2'b10);
      check("end_be_w2", {be_done, be_wdata, be_addr}, {1'b0, 32'hFF0F_0000, 10'd1});
      grant_one();
      send_word(32'hFF0F_0000);
      repeat (3) @(negedge clk);
      check("end_be_done", {be_done, be_req, be_wcnt}, {1'b1, 1'b0, 11'd2});
      check("end_le_cnt", {le_wcnt, le_addr}, {3'd1, 2'd1});
      check("end_le_no_write", le_gnts - g_le, 0);
      check("end_busy", {le_busy, be_busy}, 0);
      g_be = be_gnts;
      send_word(32'h4433_2211);
      check("end_ignore", {le_req, be_req, le_wcnt, be_wcnt}, {2'b00, 3'd1, 11'd2});
      check("end_ignore_be_writes", be_gnts - g_be, 0);
      en_toggle();
      check("end_rearm", {le_done, be_done, le_busy, be_busy}, 4'b0011);

      // Reset aborts a pending request
      send_word(32'h5566_7788);
      wait_req(1'b1, 1'b1, "rstab");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort_req", {le_req, be_req}, 0);
      check("rst_abort_cnt", {le_wcnt, be_wcnt, le_addr, be_addr}, 0);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
